// File: rtl/bpsk_tx_param_if.sv
// Transmitter-side link bundle: bit input, carrier sample, bit strobe and the serial DAC pins.
// Field names follow the DAC/board naming used by the surrounding system.
interface bpsk_tx_param_if #(
    parameter int W = 16
);
    logic                DATA;
    logic                bpsk_clk;
    logic signed [W-1:0] BPSK_out;
    logic                CS;
    logic                SCLK;
    logic                DIN;
    logic                LDAC;
    logic                OVR;

    modport master (
        input  DATA,
        output bpsk_clk, BPSK_out, CS, SCLK, DIN, LDAC, OVR
    );

    modport slave (
        output DATA,
        input  bpsk_clk, BPSK_out, CS, SCLK, DIN, LDAC, OVR
    );
endinterface

// File: rtl/bpsk_tx_param.sv
// BPSK/DBPSK sine-carrier generator with a serial DAC shifter; samples update one cycle after each tick.
// No backpressure: a tick that lands while a DAC frame is in flight is dropped and flagged on OVR.
module bpsk_tx_param #(
    parameter int W          = 16,
    parameter int SPB        = 16,
    parameter int AMPLITUDE  = 16000,
    parameter int SAMPLE_DIV = 2604,
    parameter int SCLK_DIV   = 4,
    parameter int DAC_BITS   = 16,
    parameter int DIFF       = 0
) (
    input  logic           mCLK,
    input  logic           PB,
    bpsk_tx_param_if.master tx
);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int IDX_W = (SPB > 1) ? $clog2(SPB) : 1;
    localparam int HC_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BC_W  = $clog2(DAC_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CSHI, LOAD} state_t;

    function automatic logic signed [W-1:0] sine_entry(input int k);
        real x;
        x = AMPLITUDE * $sin(2.0 * 3.14159265358979323846 * k / SPB);
        if (x >= 0.0) return W'($rtoi(x + 0.5));
        else          return W'(-$rtoi(0.5 - x));
    endfunction

    logic signed [W-1:0] lut [SPB];
    for (genvar k = 0; k < SPB; k++) begin : g_lut
        localparam logic signed [W-1:0] V = sine_entry(k);
        assign lut[k] = V;
    end

    logic [DIV_W-1:0]    div_q, div_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                sym_q, sym_d;
    logic signed [W-1:0] out_q, out_d;
    logic                bclk_q, bclk_d;
    logic                send_q, send_d;
    state_t              state_q, state_d;
    logic [HC_W-1:0]     hcnt_q, hcnt_d;
    logic [BC_W-1:0]     bcnt_q, bcnt_d;
    logic [DAC_BITS-1:0] shreg_q, shreg_d;
    logic                cs_q, cs_d, sclk_q, sclk_d, din_q, din_d, ldac_q, ldac_d, ovr_q, ovr_d;
    logic                tick, hc_last;
    logic [DAC_BITS-1:0] dw;

    // Offset-binary DAC word taken from the top DAC_BITS of the signed sample.
    assign dw = {~out_q[W-1], out_q[W-2 -: DAC_BITS-1]};

    always_comb begin
        tick    = (div_q == DIV_W'(SAMPLE_DIV - 1));
        div_d   = tick ? '0 : div_q + 1'b1;
        idx_d   = idx_q;
        sym_d   = sym_q;
        out_d   = out_q;
        bclk_d  = 1'b0;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(SPB - 1)) ? '0 : idx_q + 1'b1;
            if (idx_q == '0) sym_d = (DIFF != 0) ? (tx.DATA ^ sym_q) : tx.DATA;
            out_d  = sym_d ? -lut[idx_q] : lut[idx_q];
            bclk_d = (idx_q == '0);
        end

        send_d  = tick && (state_q == IDLE);
        ovr_d   = ovr_q | (tick && (state_q != IDLE));
        hc_last = (hcnt_q == HC_W'(SCLK_DIV - 1));
        state_d = state_q;
        hcnt_d  = hcnt_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        din_d   = din_q;
        ldac_d  = ldac_q;
        case (state_q)
            IDLE: if (send_q) begin
                shreg_d = dw << 1;
                din_d   = dw[DAC_BITS-1];
                cs_d    = 1'b0;
                sclk_d  = 1'b0;
                hcnt_d  = '0;
                bcnt_d  = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                hcnt_d = hc_last ? '0 : hcnt_q + 1'b1;
                if (hc_last) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        bcnt_d = bcnt_q + 1'b1;
                    end else begin
                        sclk_d  = 1'b0;
                        din_d   = shreg_q[DAC_BITS-1];
                        shreg_d = shreg_q << 1;
                        if (bcnt_q == BC_W'(DAC_BITS)) begin
                            cs_d    = 1'b1;
                            state_d = CSHI;
                        end
                    end
                end
            end
            CSHI: begin
                hcnt_d = hc_last ? '0 : hcnt_q + 1'b1;
                if (hc_last) begin
                    ldac_d  = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                hcnt_d = hc_last ? '0 : hcnt_q + 1'b1;
                if (hc_last) begin
                    ldac_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mCLK) begin
        if (PB) begin
            div_q   <= '0;
            idx_q   <= '0;
            sym_q   <= 1'b0;
            out_q   <= '0;
            bclk_q  <= 1'b0;
            send_q  <= 1'b0;
            state_q <= IDLE;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            din_q   <= 1'b0;
            ldac_q  <= 1'b1;
            ovr_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            sym_q   <= sym_d;
            out_q   <= out_d;
            bclk_q  <= bclk_d;
            send_q  <= send_d;
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            din_q   <= din_d;
            ldac_q  <= ldac_d;
            ovr_q   <= ovr_d;
        end
    end

    assign tx.bpsk_clk = bclk_q;
    assign tx.BPSK_out = out_q;
    assign tx.CS       = cs_q;
    assign tx.SCLK     = sclk_q;
    assign tx.DIN      = din_q;
    assign tx.LDAC     = ldac_q;
    assign tx.OVR      = ovr_q;
endmodule

// File: tb/tb_bpsk_tx_param.sv
// Bench for bpsk_tx_param: u0 plain BPSK, u1 differential, u2 with a too-short sample period.
// u0 DAC frames are checked against a queue of expected samples/words pushed when DATA is driven.
module tb_bpsk_tx_param;
    logic mclk = 1'b0;
    logic pb;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    bpsk_tx_param_if #(.W(16)) if0 ();
    bpsk_tx_param_if #(.W(16)) if1 ();
    bpsk_tx_param_if #(.W(16)) if2 ();

    bpsk_tx_param #(.W(16), .SPB(4), .AMPLITUDE(1000), .SAMPLE_DIV(64), .SCLK_DIV(1),
                    .DAC_BITS(16), .DIFF(0)) u0 (.mCLK(mclk), .PB(pb), .tx(if0));
    bpsk_tx_param #(.W(16), .SPB(4), .AMPLITUDE(1000), .SAMPLE_DIV(64), .SCLK_DIV(1),
                    .DAC_BITS(16), .DIFF(1)) u1 (.mCLK(mclk), .PB(pb), .tx(if1));
    bpsk_tx_param #(.W(16), .SPB(4), .AMPLITUDE(1000), .SAMPLE_DIV(20), .SCLK_DIV(1),
                    .DAC_BITS(16), .DIFF(0)) u2 (.mCLK(mclk), .PB(pb), .tx(if2));

    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc++;

    typedef struct { logic d0; logic d1; int s1_u1; } vec_t;
    typedef struct { int s; int w; } exp_t;
    vec_t tbl [5];
    exp_t exp_q [$];
    bit   mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int word_of(input int s);
        logic [15:0] v;
        v = s[15:0];
        return int'({~v[15], v[14:0]});
    endfunction

    task automatic push_bit(input logic d);
        int base [4];
        int s;
        base = '{0, 1000, 0, -1000};
        for (int k = 0; k < 4; k++) begin
            s = d ? -base[k] : base[k];
            exp_q.push_back('{s, word_of(s)});
        end
    endtask

    // u0 DAC frame monitor
    bit          m_prev_cs = 1'b1, m_prev_sclk = 1'b0, m_prev_ldac = 1'b1;
    logic [15:0] m_word = '0;
    int          m_bits = 0, m_cslow = 0, m_ldlow = 0;
    always @(negedge mclk) begin
        if (pb) begin
            m_word = '0; m_bits = 0; m_cslow = 0; m_ldlow = 0;
        end else if (mon_en) begin
            if (!if0.CS && m_prev_cs) begin
                m_word = '0; m_bits = 0; m_cslow = 0;
                check("frame_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("sample_at_cs_fall", if0.BPSK_out, exp_q[0].s);
            end
            if (!if0.CS) m_cslow++;
            if (if0.SCLK && !m_prev_sclk) begin
                m_word = {m_word[14:0], if0.DIN};
                m_bits++;
            end
            if (if0.CS && !m_prev_cs) check("cs_low_cycles", m_cslow, 32);
            if (!if0.LDAC) begin
                m_ldlow++;
                if (m_prev_ldac) begin
                    check("cs_high_at_ldac", if0.CS, 1);
                    check("sclk_rises", m_bits, 16);
                    if (exp_q.size() > 0) begin
                        check("spi_word", int'(m_word), exp_q[0].w);
                        void'(exp_q.pop_front());
                    end
                end
            end else if (!m_prev_ldac) begin
                check("ldac_low_cycles", m_ldlow, 1);
                m_ldlow = 0;
            end
        end
        m_prev_cs = if0.CS; m_prev_sclk = if0.SCLK; m_prev_ldac = if0.LDAC;
    end

    // u2 frame completeness monitor
    bit f2_prev_cs = 1'b1, f2_prev_sclk = 1'b0, f2_prev_ldac = 1'b1;
    int f2_rises = 0, f2_frames = 0;
    always @(negedge mclk) begin
        if (pb) begin
            f2_rises = 0; f2_frames = 0;
        end else begin
            if (!if2.CS && f2_prev_cs) f2_rises = 0;
            if (if2.SCLK && !f2_prev_sclk) f2_rises++;
            if (!if2.LDAC && f2_prev_ldac) begin
                check("u2_frame_rises", f2_rises, 16);
                f2_frames++;
            end
        end
        f2_prev_cs = if2.CS; f2_prev_sclk = if2.SCLK; f2_prev_ldac = if2.LDAC;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        int   n, k, t_prev;
        logic nd0, nd1, prev;
        pb = 1'b1;
        if0.DATA = 1'b0; if1.DATA = 1'b0; if2.DATA = 1'b0;
        tbl[0] = '{1'b0, 1'b1, -1000};
        tbl[1] = '{1'b0, 1'b1,  1000};
        tbl[2] = '{1'b1, 1'b0,  1000};
        tbl[3] = '{1'b0, 1'b1, -1000};
        tbl[4] = '{1'b1, 1'b0, -1000};

        repeat (10) @(negedge mclk);
        check("rst_BPSK_out", if0.BPSK_out, 0);
        check("rst_bpsk_clk", if0.bpsk_clk, 0);
        check("rst_CS", if0.CS, 1);
        check("rst_SCLK", if0.SCLK, 0);
        check("rst_DIN", if0.DIN, 0);
        check("rst_LDAC", if0.LDAC, 1);
        check("rst_OVR", if0.OVR, 0);

        if0.DATA = tbl[0].d0; if1.DATA = tbl[0].d1;
        push_bit(tbl[0].d0);
        mon_en = 1'b1;
        pb = 1'b0;
        n = 0;
        do begin @(negedge mclk); n++; end while (!if0.bpsk_clk && n < 200);
        check("first_bpsk_clk_latency", n, 64);
        t_prev = cyc;

        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                n = 0;
                do begin @(negedge mclk); n++; end while (!if0.bpsk_clk && n < 400);
                check("bpsk_clk_period", cyc - t_prev, 256);
                t_prev = cyc;
            end
            nd0 = (i < 4) ? tbl[i+1].d0 : tbl[i].d0;
            nd1 = (i < 4) ? tbl[i+1].d1 : tbl[i].d1;
            if0.DATA = ~nd0; if1.DATA = ~nd1;
            repeat (64) @(negedge mclk);
            check("u1_second_sample", if1.BPSK_out, tbl[i].s1_u1);
            repeat (40) @(negedge mclk);
            if0.DATA = nd0; if1.DATA = nd1;
            if (i < 4) push_bit(nd0);
        end
        n = 0;
        while (exp_q.size() > 0 && n < 400) begin @(negedge mclk); n++; end
        check("u0_queue_drained", exp_q.size(), 0);
        mon_en = 1'b0;
        check("u2_ovr_sticky", if2.OVR, 1);

        // Abort a u0 frame carrying a nonzero sample on its 5th SCLK rise.
        n = 0;
        while (!(!if0.CS && if0.BPSK_out != 0) && n < 400) begin @(negedge mclk); n++; end
        check("u0_pre_abort_sample", if0.BPSK_out, -1000);
        prev = if0.SCLK; k = 0; n = 0;
        while (k < 5 && n < 100) begin
            @(negedge mclk); n++;
            if (if0.SCLK && !prev) k++;
            prev = if0.SCLK;
        end
        check("abort_rises_seen", k, 5);
        pb = 1'b1;
        if0.DATA = 1'b0;
        @(negedge mclk);
        check("abort_CS", if0.CS, 1);
        check("abort_SCLK", if0.SCLK, 0);
        check("abort_LDAC", if0.LDAC, 1);
        check("abort_BPSK_out", if0.BPSK_out, 0);
        check("abort_DIN", if0.DIN, 0);
        check("pb_clears_ovr", if2.OVR, 0);
        repeat (2) @(negedge mclk);
        check("abort_no_ldac", if0.LDAC, 1);

        exp_q.delete();
        push_bit(1'b0);
        mon_en = 1'b1;
        pb = 1'b0;
        repeat (20) @(negedge mclk);
        check("u2_tick1_sample", if2.BPSK_out, 0);
        check("u2_ovr_after_tick1", if2.OVR, 0);
        repeat (19) @(negedge mclk);
        check("u2_ovr_before_tick2", if2.OVR, 0);
        @(negedge mclk);
        check("u2_ovr_at_tick2", if2.OVR, 1);
        check("u2_tick2_sample", if2.BPSK_out, 1000);
        n = 40;
        while (exp_q.size() > 0 && n < 600) begin @(negedge mclk); n++; end
        check("u0_restart_drained", exp_q.size(), 0);
        mon_en = 1'b0;
        while (n < 430) begin @(negedge mclk); n++; end
        check("u2_frames_sent", f2_frames, 10);
        check("u2_ovr_held", if2.OVR, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bpsk_tx_param.md
# bpsk_tx_param

Parametrised BPSK transmitter, successor to `BPSK_tx`. It latches one NRZ bit per symbol and generates a sampled sine carrier with phase 0 or π per bit. Differential encoding (DBPSK) is optional. Each sample is streamed to a serial DAC over an SPI-style CS/SCLK/DIN/LDAC link. It sits between the bit source (push-button/UART data path) and the external DAC, and exposes `bpsk_clk` as the bit-rate strobe for upstream logic and benches.

## Interface
- `W`, 16 — width of `BPSK_out`, two's complement.
- `SPB`, 16 — samples per bit, equal to one carrier cycle per bit; ≥ 4.
- `AMPLITUDE`, 16000 — peak LUT value; ≤ 2^(W-1)-1, so negation never overflows.
- `SAMPLE_DIV`, 2604 — `mCLK` cycles per output sample; ≥ 2·`SCLK_DIV`·(`DAC_BITS`+1)+2 for overrun-free operation.
- `SCLK_DIV`, 4 — `mCLK` cycles per SCLK half-period; ≥ 1.
- `DAC_BITS`, 16 — DAC word length; ≤ `W`.
- `DIFF`, 0 — 1 enables differential encoding.
- `mCLK` input 1 — system clock. All logic is clocked on the rising edge.
- `PB` input 1 — reset, synchronous, active-high.
- `DATA` input 1 — NRZ bit, sampled only at bit start.
- `bpsk_clk` output 1 — one-cycle pulse marking the first sample of each bit.
- `BPSK_out` output W — current signed carrier sample.
- `CS` output 1 — DAC chip select, active-low.
- `SCLK` output 1 — DAC serial clock. The DAC samples `DIN` on the rising edge.
- `DIN` output 1 — DAC serial data, MSB first.
- `LDAC` output 1 — DAC load, active-low pulse.
- `OVR` output 1 — sticky sample-overrun flag.

## Operation
- **LUT.** The sine table holds `SPB` entries with LUT[k] = round(`AMPLITUDE`·sin(2πk/`SPB`)). It is built at elaboration.
- **Sample divider.** `div` counts 0..`SAMPLE_DIV`-1 and wraps. `tick` is asserted when `div` = `SAMPLE_DIV`-1.
- **Sample index.** `idx` counts 0..`SPB`-1 and advances by one per tick, wrapping to 0.
- **Bit latch.** On a tick with `idx`=0:
  - `DIFF`=0: sym ← `DATA`.
  - `DIFF`=1: sym ← `DATA` XOR sym_prev, where sym_prev is the value held since the last bit (reset value 0).
  - `DATA` is ignored at all other times.
- **Sample value.** On every tick, `BPSK_out` ← LUT[idx] if the new sym is 0, and −LUT[idx] if the new sym is 1.
- **DAC word.** dw = {~`BPSK_out`[W-1], `BPSK_out`[W-2 : W-`DAC_BITS`]}, i.e. offset binary, top `DAC_BITS` bits.
- **SPI FSM.** States IDLE → SHIFT → CSHI → LOAD → IDLE.
  - IDLE: on the cycle after a tick, load dw, drive `CS`=0 and `DIN`=dw MSB, go to SHIFT.
  - SHIFT: `SCLK` toggles every `SCLK_DIV` cycles, starting low. `DIN` advances to the next bit on each falling edge. After `DAC_BITS` rising edges and the following falling edge, go to CSHI with `CS`=1.
  - CSHI: hold for `SCLK_DIV` cycles, then go to LOAD with `LDAC`=0.
  - LOAD: hold for `SCLK_DIV` cycles, then drive `LDAC`=1 and go to IDLE.
- **Overrun.** If a tick occurs while the FSM is not in IDLE:
  - `BPSK_out` still updates.
  - The sample is not sent and the running frame continues undisturbed.
  - `OVR` ← 1 and stays 1 until `PB`.

## Timing
- **Reset values** (the cycle after `PB` is sampled high):
  - Outputs: `BPSK_out`=0, `bpsk_clk`=0, `CS`=1, `SCLK`=0, `DIN`=0, `LDAC`=1, `OVR`=0.
  - Internal: `div`=0, `idx`=0, sym=sym_prev=0, FSM in IDLE.
- `PB` asserted mid-frame aborts the frame immediately; no partial `LDAC` pulse is issued.
- The first tick after `PB` falls occurs `SAMPLE_DIV` cycles later.
- `BPSK_out` and `bpsk_clk` are registered: both change on the edge that ends the tick cycle.
- `bpsk_clk` is high for exactly one cycle every `SPB`·`SAMPLE_DIV` cycles.
- The bench may change `DATA` any time after `bpsk_clk`; the value is taken at the next bit start.
- `CS` falls one cycle after `BPSK_out` updates.
- Frame length is 2·`SCLK_DIV`·`DAC_BITS` (SHIFT) + 2·`SCLK_DIV` (CSHI + LOAD) cycles.
- `PB` and a tick in the same cycle: `PB` wins.

## Test plan
All scenarios use `W`=16, `SPB`=4, `AMPLITUDE`=1000, `SAMPLE_DIV`=64, `SCLK_DIV`=1, `DAC_BITS`=16, unless stated otherwise.

1. **Reset.** Hold `PB`=1 for 10 cycles → all outputs at their reset values.
   - The first `bpsk_clk` occurs 64 cycles after `PB` falls.
2. **Constant DATA=0.** → `BPSK_out` cycles 0, 1000, 0, −1000.
   - `bpsk_clk` period is 256 cycles.
   - SPI words captured on `SCLK` rising edges are 0x8000, 0x83E8, 0x8000, 0x7C18.
   - Each `CS` low lasts 32 cycles, followed by `CS` high, then a 1-cycle `LDAC` low.
3. **Bit pattern 1,0,1 with `DIFF`=0.** → per-bit sequences (0,−1000,0,1000), (0,1000,0,−1000), (0,−1000,0,1000).
   - A `DATA` toggle mid-bit has no effect.
4. **`DIFF`=1, DATA 1,1,0,1.** → symbols 1,0,0,1.
   - The second sample of each bit is −1000, 1000, 1000, −1000.
5. **Overrun.** `SAMPLE_DIV`=20 → `OVR` rises on the second tick and stays high.
   - Every second sample is dropped; each transmitted frame stays complete (16 SCLK rising edges, then `LDAC`).
   - `PB` clears `OVR`.
6. **Reset mid-frame.** Assert `PB` on the 5th `SCLK` rising edge → next cycle `CS`=1, `SCLK`=0, `LDAC`=1, `BPSK_out`=0.
   - After release, the sequence restarts at `idx` 0.
